// File: rtl/pb_conditioner.sv
// rtl/pb_conditioner.sv - multi-channel push-button synchroniser, debouncer and edge detector
//
// Each channel runs independently: a 2-flop synchroniser feeds a debounce
// counter guarding a stable-level register. Once a changed level has held for
// DEBOUNCE_CYCLES consecutive samples, it is accepted. An accepted change
// updates the pressed level and fires a one-cycle press or release strobe.
//
// Optional feature macro: PB_AUTOREPEAT_EN
//   defined   - a held button re-fires pressPulse REPEAT_DELAY cycles after
//               the initial press, then every REPEAT_RATE cycles.
//   undefined - exactly one pressPulse per accepted press; REPEAT_* ignored.
//
// Ports:
//   clock        in   1         rising-edge system clock
//   reset        in   1         synchronous active-high reset
//   in           in   CHANNELS  raw asynchronous button levels
//   pressed      out  CHANNELS  debounced level, 1 = pressed (any IDLE_LEVEL)
//   pressPulse   out  CHANNELS  one-cycle strobe per accepted press / repeat
//   releasePulse out  CHANNELS  one-cycle strobe per accepted release
//   anyPress     out  1         OR of all pressPulse bits

module pb_conditioner #(
  parameter int   CHANNELS        = 3,
  parameter int   CNT_W           = 16,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic IDLE_LEVEL      = 1'b1,
  parameter int   REPEAT_DELAY    = 25000000,
  parameter int   REPEAT_RATE     = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] pressPulse,
  output logic [CHANNELS-1:0] releasePulse,
  output logic                anyPress
);

  // Counter value on the edge where a changed level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef PB_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
`endif

  // Elaboration-time parameter sanity checks.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce
    $error("pb_conditioner: DEBOUNCE_CYCLES out of range for CNT_W");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
    $error("pb_conditioner: REPEAT_DELAY and REPEAT_RATE must be at least 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             st;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             rpt_fire;
    logic             pressed_q;
    logic             press_q;
    logic             release_q;

    // The synchronised level has disagreed with the stable level for the
    // full window; this edge commits it.
    assign accept = (s2 != st) && (cnt == CNT_LAST);

    always_ff @(posedge clock) begin
      if (reset) begin
        s1  <= IDLE_LEVEL;
        s2  <= IDLE_LEVEL;
        st  <= IDLE_LEVEL;
        cnt <= '0;
      end else begin
        s1 <= in[i];
        s2 <= s1;
        if (s2 == st) begin
          // Any return to the stable level restarts the whole window.
          cnt <= '0;
        end else if (accept) begin
          st  <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

`ifdef PB_AUTOREPEAT_EN
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;

    // A release being accepted on this edge suppresses any repeat strobe.
    assign rpt_fire = pressed_q && !accept &&
                      (rpt_cnt == (rpt_first ? DELAY_LAST : RATE_LAST));

    always_ff @(posedge clock) begin
      if (reset || !pressed_q || accept) begin
        // Idle, or the edge of the initial press: arm for the first delay.
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (rpt_fire) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end else begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clock) begin
      if (reset) begin
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        if (accept) begin
          pressed_q <= (s2 != IDLE_LEVEL);
        end
        press_q   <= (accept && (s2 != IDLE_LEVEL)) || rpt_fire;
        release_q <= accept && (s2 == IDLE_LEVEL);
      end
    end

    assign pressed[i]      = pressed_q;
    assign pressPulse[i]   = press_q;
    assign releasePulse[i] = release_q;
  end

  assign anyPress = |pressPulse;

endmodule

// File: tb/tb_pb_conditioner.sv
// tb/tb_pb_conditioner.sv - self-checking bench for pb_conditioner with a behavioural model

module tb_pb_conditioner;

  localparam int CH   = 3;
  localparam int D    = 4;
  localparam bit IDLE = 1'b1;
  localparam int RD   = 10;
  localparam int RR   = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] btn;
  logic [CH-1:0] pressed;
  logic [CH-1:0] press_pulse;
  logic [CH-1:0] release_pulse;
  logic          any_press;

  int checks = 0;
  int errors = 0;

  pb_conditioner #(
    .CHANNELS       (CH),
    .CNT_W          (16),
    .DEBOUNCE_CYCLES(D),
    .IDLE_LEVEL     (IDLE),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in          (btn),
    .pressed     (pressed),
    .pressPulse  (press_pulse),
    .releasePulse(release_pulse),
    .anyPress    (any_press)
  );

  always #5 clock = ~clock;

  // Behavioural model: the stable level flips once the last D synchronised
  // samples (input delayed by two edges) all disagree with it.
  bit            dq    [CH][2];
  bit            st_m  [CH];
  bit            hist  [CH][D];
  int            fill  [CH];
  int            ptime [CH];
  int            mcyc = 0;
  bit            model_ok = 0;
  logic [CH-1:0] e_pressed = '0;
  logic [CH-1:0] e_pp = '0;
  logic [CH-1:0] e_rp = '0;

  always @(posedge clock) begin : model
    bit s2b;
    bit acc;
    int el;
    mcyc++;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        dq[c][0] = IDLE;
        dq[c][1] = IDLE;
        st_m[c]  = IDLE;
        fill[c]  = 0;
        ptime[c] = 0;
      end
      e_pressed = '0;
      e_pp      = '0;
      e_rp      = '0;
      model_ok  = 1;
    end else begin
      for (int c = 0; c < CH; c++) begin
        s2b      = dq[c][0];
        dq[c][0] = dq[c][1];
        dq[c][1] = btn[c];
        for (int k = D - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = s2b;
        if (fill[c] < D) fill[c]++;
        acc = (fill[c] == D);
        for (int k = 0; k < D; k++) if (hist[c][k] == st_m[c]) acc = 0;
        e_pp[c] = 1'b0;
        e_rp[c] = 1'b0;
        if (acc) begin
          st_m[c] = ~st_m[c];
          fill[c] = 0;
          if (st_m[c] != IDLE) begin
            e_pp[c]  = 1'b1;
            ptime[c] = mcyc;
          end else begin
            e_rp[c] = 1'b1;
          end
        end
`ifdef PB_AUTOREPEAT_EN
        if (!acc && st_m[c] != IDLE) begin
          el = mcyc - ptime[c];
          if (el == RD || (el > RD && (el - RD) % RR == 0)) e_pp[c] = 1'b1;
        end
`endif
        e_pressed[c] = (st_m[c] != IDLE);
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: dut=%0h model=%0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (model_ok) begin
      cmp("pressed", 32'(pressed), 32'(e_pressed));
      cmp("pressPulse", 32'(press_pulse), 32'(e_pp));
      cmp("releasePulse", 32'(release_pulse), 32'(e_rp));
      cmp("anyPress", 32'(any_press), 32'(|e_pp));
    end
  end

  // Hand-computed expectation checked against both the DUT and the model.
  task automatic check_lit(input string name, input logic [31:0] dut_v,
                           input logic [31:0] mdl_v, input logic [31:0] want);
    checks++;
    if (dut_v !== want) begin
      errors++;
      $display("FAIL %s: dut=%0h required=%0h", name, dut_v, want);
    end
    checks++;
    if (mdl_v !== want) begin
      errors++;
      $display("FAIL %s: model=%0h required=%0h", name, mdl_v, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int d_cnt;
    int m_cnt;
    int d_rp;
    int m_rp;
    logic [31:0] dmask;
    logic [31:0] mmask;
    logic [31:0] wmask;
    int hold [CH];

    reset = 1'b1;
    btn   = 3'b111;
    tick(3);
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_lit("idle_pressed", 32'(pressed), 32'(e_pressed), 0);
      check_lit("idle_pulses", 32'({press_pulse, release_pulse}), 32'({e_pp, e_rp}), 0);
      check_lit("idle_any", 32'(any_press), 32'(|e_pp), 0);
    end

    // Press on channel 0: strobe after the sixth edge.
    btn[0] = 1'b0;
    tick(5);
    check_lit("press0_early", 32'(press_pulse[0]), 32'(e_pp[0]), 0);
    tick(1);
    check_lit("press0_pressed", 32'(pressed[0]), 32'(e_pressed[0]), 1);
    check_lit("press0_pulse", 32'(press_pulse[0]), 32'(e_pp[0]), 1);
    check_lit("press0_any", 32'(any_press), 32'(|e_pp), 1);
    tick(1);
    check_lit("press0_pulse_end", 32'(press_pulse[0]), 32'(e_pp[0]), 0);
    check_lit("press0_any_end", 32'(any_press), 32'(|e_pp), 0);
    check_lit("press0_held", 32'(pressed[0]), 32'(e_pressed[0]), 1);

    // Three-cycle glitch on channel 1 is filtered.
    d_cnt = 0; m_cnt = 0;
    btn[1] = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick(1);
      if (i == 2) btn[1] = 1'b1;
      d_cnt += int'(press_pulse[1]) + int'(release_pulse[1]) + int'(pressed[1]);
      m_cnt += int'(e_pp[1]) + int'(e_rp[1]) + int'(e_pressed[1]);
    end
    check_lit("glitch3_activity", d_cnt, m_cnt, 0);

    // Five-cycle low: one press then one release.
    btn[1] = 1'b0;
    tick(5);
    btn[1] = 1'b1;
    tick(1);
    check_lit("low5_pulse", 32'(press_pulse[1]), 32'(e_pp[1]), 1);
    check_lit("low5_pressed", 32'(pressed[1]), 32'(e_pressed[1]), 1);
    d_cnt = 0; m_cnt = 0; d_rp = 0; m_rp = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      d_cnt += int'(press_pulse[1]);
      m_cnt += int'(e_pp[1]);
      d_rp  += int'(release_pulse[1]);
      m_rp  += int'(e_rp[1]);
    end
    check_lit("low5_extra_press", d_cnt, m_cnt, 0);
    check_lit("low5_release_count", d_rp, m_rp, 1);

    // Release of channel 0.
    btn[0] = 1'b1;
    tick(5);
    check_lit("rel0_early", 32'(release_pulse[0]), 32'(e_rp[0]), 0);
    tick(1);
    check_lit("rel0_pulse", 32'(release_pulse[0]), 32'(e_rp[0]), 1);
    check_lit("rel0_pressed", 32'(pressed[0]), 32'(e_pressed[0]), 0);
    check_lit("rel0_no_press", 32'(press_pulse[0]), 32'(e_pp[0]), 0);
    tick(1);
    check_lit("rel0_pulse_end", 32'(release_pulse[0]), 32'(e_rp[0]), 0);

    // Simultaneous presses on channels 1 and 2.
    btn[2:1] = 2'b00;
    tick(5);
    check_lit("dual_early", 32'(press_pulse), 32'(e_pp), 0);
    tick(1);
    check_lit("dual_pulse", 32'(press_pulse), 32'(e_pp), 3'b110);
    check_lit("dual_any", 32'(any_press), 32'(|e_pp), 1);
    tick(1);
    check_lit("dual_pulse_end", 32'(press_pulse), 32'(e_pp), 0);
    check_lit("dual_any_end", 32'(any_press), 32'(|e_pp), 0);
    btn[2:1] = 2'b11;
    tick(10);

    // Reset in the middle of a debounce count, button held through it.
    btn[0] = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    check_lit("rst_pressed", 32'(pressed), 32'(e_pressed), 0);
    check_lit("rst_pulses", 32'({press_pulse, release_pulse, any_press}),
              32'({e_pp, e_rp, |e_pp}), 0);
    tick(1);
    reset = 1'b0;
    tick(5);
    check_lit("post_rst_early", 32'(press_pulse[0]), 32'(e_pp[0]), 0);
    tick(1);
    check_lit("post_rst_pulse", 32'(press_pulse[0]), 32'(e_pp[0]), 1);
    check_lit("post_rst_pressed", 32'(pressed[0]), 32'(e_pressed[0]), 1);
    btn[0] = 1'b1;
    tick(10);

    // Long hold on channel 2: repeat strobes only with auto-repeat built in.
    btn[2] = 1'b0;
    tick(6);
    check_lit("hold2_initial", 32'(press_pulse[2]), 32'(e_pp[2]), 1);
    dmask = '0; mmask = '0;
    for (int k = 1; k <= 22; k++) begin
      tick(1);
      if (press_pulse[2]) dmask[k] = 1'b1;
      if (e_pp[2]) mmask[k] = 1'b1;
    end
`ifdef PB_AUTOREPEAT_EN
    wmask = (32'd1 << 10) | (32'd1 << 15) | (32'd1 << 20);
`else
    wmask = 32'd0;
`endif
    check_lit("hold2_repeat_mask", dmask, mmask, wmask);
    btn[2] = 1'b1;
    tick(6);
    check_lit("hold2_release", 32'(release_pulse[2]), 32'(e_rp[2]), 1);
    check_lit("hold2_release_no_press", 32'(press_pulse[2]), 32'(e_pp[2]), 0);
    d_cnt = 0; m_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      d_cnt += int'(press_pulse[2]) + int'(release_pulse[2]);
      m_cnt += int'(e_pp[2]) + int'(e_rp[2]);
    end
    check_lit("hold2_quiet_after", d_cnt, m_cnt, 0);

    // Randomised bouncing, long holds and occasional resets.
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          btn[c]  = ~btn[c];
          hold[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 40))
                                                : int'($urandom_range(1, 9));
        end else begin
          hold[c]--;
        end
      end
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      tick(1);
    end

    reset = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
